lane_objects: RTL and testbench
===============================

Name: lane_objects

Overview:
Parametrised successor to the river-log mover. It animates NUM_LANES lanes of OBJS_PER_LANE horizontally scrolling objects (logs, cars or turtles). Each lane has its own runtime-writable speed divider, object length and direction. The block sits between game control and the renderer/collision logic. It also exports per-lane step pulses so the player-carry logic can move the frog with the object it rides.

Parameters:
NUM_LANES, 6, number of lanes
OBJS_PER_LANE, 3, objects per lane
X_W, 10, x-coordinate width
CNT_W, 24, speed counter width
X_LEFT, 96, left playfield edge
X_RIGHT, 544, right playfield edge
SPACING, 150, initial gap between objects in a lane
MAX_LEN, 96, maximum object length; must be <= X_LEFT
DEF_DIV, 150000, reset speed divider for every lane
DEF_LEN, 64, reset object length for every lane

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = counters advance; 0 = freeze (pause)
restart  in  1  one-cycle pulse; reload initial positions, keep config
cfg_we  in  1  config write strobe
cfg_lane  in  $clog2(NUM_LANES)  target lane
cfg_div  in  CNT_W  new speed divider
cfg_len  in  X_W  new object length
cfg_dir  in  1  0 = move right, 1 = move left
obj_x  out  NUM_LANES*OBJS_PER_LANE*X_W  packed left-edge x; index = lane*OBJS_PER_LANE + obj
lane_len  out  NUM_LANES*X_W  current length per lane
lane_dir  out  NUM_LANES  current direction per lane
lane_step  out  NUM_LANES  one-cycle pulse when that lane's objects moved

Behaviour:
- Clocking and reset: single clock, clk. reset is synchronous and active-high and overrides everything.
- Reset state:
  - obj_x[l][k] = X_LEFT + k*SPACING
  - counters = 0
  - div = DEF_DIV
  - len = DEF_LEN
  - dir = l[0] (even lanes move right, odd lanes move left)
  - lane_step = 0
- Counter, per lane when enable=1:
  - If cnt >= div: cnt <= 0, and on the next edge positions update and lane_step[l] = 1.
  - Otherwise cnt <= cnt+1.
  - Latency: the terminal count seen at edge t produces the new obj_x and lane_step high after edge t+1. lane_step is registered and lasts exactly one cycle.
  - div = 0 means a step every other cycle (hit, then update).
- enable=0: counters, positions and pending steps hold; lane_step = 0.
- Right motion, per object: if x >= X_RIGHT then x <= X_LEFT - len, else x+1.
- Left motion, per object: if x <= X_LEFT - len then x <= X_RIGHT, else x-1.
- All arithmetic is unsigned X_W. No negative values occur because len <= MAX_LEN <= X_LEFT.
- Config write (cfg_we=1, cfg_lane < NUM_LANES):
  - At the next edge, div, len and dir load; len is clamped to MAX_LEN; the lane counter clears; any pending step for that lane is cancelled.
  - Positions are unchanged.
  - cfg_lane >= NUM_LANES is ignored.
- Write and terminal count on the same lane in the same cycle: the write wins and no step occurs.
- restart: all positions reload to initial values, counters and pending steps clear, config is retained.
- restart together with cfg_we: both take effect.
- A direction change mid-flight continues from the current x in the new direction with no jump.

Decomposition:
- Package lane_objects_pkg:
  - X_W and the geometry constants
  - typedef enum logic {DIR_RIGHT, DIR_LEFT} dir_t
  - struct lane_cfg_t {div, len, dir}
- Sub-module lane_mover: one lane's config register, counter, step pipeline and OBJS_PER_LANE position registers. Instantiated NUM_LANES times by generate in lane_objects, with cfg_we decoded per lane.

Test Plan:
1. Reset with DEF_DIV=3 -> lane0 obj_x = 96/246/396, lane_step=0. Then enable=1 -> lane0 lane_step pulses every 5th cycle, obj0 goes 96→97→98.
2. Right wrap: lane0 obj at 544, len 64, next step -> x = 32. Following step -> 33.
3. Left wrap: lane1 (dir=1) obj at 32, len 64, step -> 544. From 100, step -> 99.
4. cfg_we lane2 with div=0, len=200, dir=1 -> lane_len[2] = 96 (clamped); lane2 steps every 2 cycles moving left. cfg_lane=7 -> no register changes.
5. enable=0 for 20 cycles mid-count -> obj_x and counters frozen, no lane_step. Re-enable resumes the remaining count exactly.
6. restart coincident with a lane0 terminal count -> positions = initial, no lane_step, config unchanged. Write coincident with terminal count -> no step, counter = 0.

Source files
------------

// File: rtl/lane_objects_pkg.sv
// Shared widths, default playfield geometry and per-lane configuration types
// for the scrolling lane-object animator.
package lane_objects_pkg;

    localparam int X_W         = 10;
    localparam int CNT_W       = 24;
    localparam int LEFT_EDGE   = 96;
    localparam int RIGHT_EDGE  = 544;
    localparam int OBJ_SPACING = 150;
    localparam int LEN_MAX     = 96;
    localparam int DIV_RESET   = 150000;
    localparam int LEN_RESET   = 64;

    typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_t;

    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic [X_W-1:0]   len;
        dir_t             dir;
    } lane_cfg_t;

    function automatic logic [X_W-1:0] clamp_len(input logic [X_W-1:0] len,
                                                 input logic [X_W-1:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/lane_objects_lane_mover.sv
// One lane: config register, speed counter, one-cycle step pipeline and the
// position registers of every object in the lane.
module lane_mover
    import lane_objects_pkg::*;
#(
    parameter int OBJS     = 3,
    parameter int LANE_IDX = 0,
    parameter int X_LEFT   = LEFT_EDGE,
    parameter int X_RIGHT  = RIGHT_EDGE,
    parameter int SPACING  = OBJ_SPACING,
    parameter int MAX_LEN  = LEN_MAX,
    parameter int DEF_DIV  = DIV_RESET,
    parameter int DEF_LEN  = LEN_RESET
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  restart,
    input  logic                  cfg_we,
    input  logic [CNT_W-1:0]      cfg_div,
    input  logic [X_W-1:0]        cfg_len,
    input  dir_t                  cfg_dir,
    output logic [OBJS*X_W-1:0]   x,
    output logic [X_W-1:0]        len,
    output dir_t                  dir,
    output logic                  step
);

    localparam logic [X_W-1:0] LEFT_V    = X_W'(X_LEFT);
    localparam logic [X_W-1:0] RIGHT_V   = X_W'(X_RIGHT);
    localparam logic [X_W-1:0] MAX_LEN_V = X_W'(MAX_LEN);
    localparam dir_t           DIR_INIT  = (LANE_IDX % 2 == 1) ? DIR_LEFT : DIR_RIGHT;

    lane_cfg_t        cfg_reg;
    lane_cfg_t        cfg_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             pending_reg;
    logic             step_reg;
    logic             clear_now;
    logic             move_now;
    logic [X_W-1:0]   wrap_lo;

    always_comb begin
        cfg_next     = cfg_reg;
        cfg_next.div = cfg_div;
        cfg_next.len = clamp_len(cfg_len, MAX_LEN_V);
        cfg_next.dir = cfg_dir;
    end

    // A config write or restart cancels any half-finished step in this lane.
    assign clear_now = restart | cfg_we;
    assign move_now  = enable & pending_reg & ~clear_now;
    assign wrap_lo   = LEFT_V - cfg_reg.len;

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_reg.div <= CNT_W'(DEF_DIV);
            cfg_reg.len <= X_W'(DEF_LEN);
            cfg_reg.dir <= DIR_INIT;
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
            step_reg    <= 1'b0;
        end else begin
            step_reg <= 1'b0;
            if (cfg_we) begin
                cfg_reg <= cfg_next;
            end
            if (clear_now) begin
                cnt_reg     <= '0;
                pending_reg <= 1'b0;
            end else if (enable) begin
                // The update cycle consumes one tick, so a lane moves every div+2 cycles.
                if (pending_reg) begin
                    pending_reg <= 1'b0;
                    step_reg    <= 1'b1;
                end else if (cnt_reg >= cfg_reg.div) begin
                    cnt_reg     <= '0;
                    pending_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < OBJS; gi++) begin : g_obj
            localparam logic [X_W-1:0] X_INIT = X_W'(X_LEFT + gi * SPACING);
            logic [X_W-1:0] x_reg;
            logic [X_W-1:0] x_next;

            always_comb begin
                x_next = x_reg;
                if (cfg_reg.dir == DIR_RIGHT) begin
                    x_next = (x_reg >= RIGHT_V) ? wrap_lo : x_reg + 1'b1;
                end else begin
                    x_next = (x_reg <= wrap_lo) ? RIGHT_V : x_reg - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset || restart) begin
                    x_reg <= X_INIT;
                end else if (move_now) begin
                    x_reg <= x_next;
                end
            end

            assign x[gi*X_W +: X_W] = x_reg;
        end
    endgenerate

    assign len  = cfg_reg.len;
    assign dir  = cfg_reg.dir;
    assign step = step_reg;

endmodule

// File: rtl/lane_objects.sv
// Animates NUM_LANES lanes of horizontally scrolling objects; each lane has its
// own speed divider, object length and direction, writable at runtime.
module lane_objects
    import lane_objects_pkg::*;
#(
    parameter int NUM_LANES     = 6,
    parameter int OBJS_PER_LANE = 3,
    parameter int X_LEFT        = LEFT_EDGE,
    parameter int X_RIGHT       = RIGHT_EDGE,
    parameter int SPACING       = OBJ_SPACING,
    parameter int MAX_LEN       = LEN_MAX,
    parameter int DEF_DIV       = DIV_RESET,
    parameter int DEF_LEN       = LEN_RESET
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic                                  restart,
    input  logic                                  cfg_we,
    input  logic [$clog2(NUM_LANES)-1:0]          cfg_lane,
    input  logic [CNT_W-1:0]                      cfg_div,
    input  logic [X_W-1:0]                        cfg_len,
    input  logic                                  cfg_dir,
    output logic [NUM_LANES*OBJS_PER_LANE*X_W-1:0] obj_x,
    output logic [NUM_LANES*X_W-1:0]              lane_len,
    output logic [NUM_LANES-1:0]                  lane_dir,
    output logic [NUM_LANES-1:0]                  lane_step
);

    localparam int LANE_W = $clog2(NUM_LANES);

    // Lane indices past NUM_LANES match no decoder and are dropped.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic lane_we;
            dir_t lane_dir_w;

            assign lane_we      = cfg_we && (cfg_lane == LANE_W'(gi));
            assign lane_dir[gi] = lane_dir_w;

            lane_mover #(
                .OBJS     (OBJS_PER_LANE),
                .LANE_IDX (gi),
                .X_LEFT   (X_LEFT),
                .X_RIGHT  (X_RIGHT),
                .SPACING  (SPACING),
                .MAX_LEN  (MAX_LEN),
                .DEF_DIV  (DEF_DIV),
                .DEF_LEN  (DEF_LEN)
            ) u_lane (
                .clk     (clk),
                .reset   (reset),
                .enable  (enable),
                .restart (restart),
                .cfg_we  (lane_we),
                .cfg_div (cfg_div),
                .cfg_len (cfg_len),
                .cfg_dir (dir_t'(cfg_dir)),
                .x       (obj_x[gi*OBJS_PER_LANE*X_W +: OBJS_PER_LANE*X_W]),
                .len     (lane_len[gi*X_W +: X_W]),
                .dir     (lane_dir_w),
                .step    (lane_step[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_lane_objects.sv
// Randomised and directed checks of lane_objects against a tick-counting lane model.
module tb_lane_objects;
    import lane_objects_pkg::*;

    localparam int NL   = 6;
    localparam int OPL  = 3;
    localparam int DDIV = 3;
    localparam int DLEN = 64;
    localparam int XL   = 96;
    localparam int XR   = 544;
    localparam int SP   = 150;
    localparam int MLEN = 96;

    logic                   clk = 1'b0;
    logic                   reset, enable, restart, cfg_we, cfg_dir;
    logic [2:0]             cfg_lane;
    logic [CNT_W-1:0]       cfg_div;
    logic [X_W-1:0]         cfg_len;
    logic [NL*OPL*X_W-1:0]  obj_x;
    logic [NL*X_W-1:0]      lane_len;
    logic [NL-1:0]          lane_dir;
    logic [NL-1:0]          lane_step;

    int vectors = 0;
    int miscompares = 0;

    // Model: positions, config and enabled edges since the last counter clear.
    int          m_x [NL][OPL];
    int          m_len [NL];
    int          m_div [NL];
    int          m_dir [NL];
    int          m_tick [NL];
    logic [NL-1:0] m_step;

    lane_objects #(
        .NUM_LANES(NL), .OBJS_PER_LANE(OPL), .X_LEFT(XL), .X_RIGHT(XR),
        .SPACING(SP), .MAX_LEN(MLEN), .DEF_DIV(DDIV), .DEF_LEN(DLEN)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart),
        .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_div(cfg_div),
        .cfg_len(cfg_len), .cfg_dir(cfg_dir), .obj_x(obj_x),
        .lane_len(lane_len), .lane_dir(lane_dir), .lane_step(lane_step)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        m_step = '0;
        for (int l = 0; l < NL; l++) begin
            if (reset) begin
                m_len[l] = DLEN; m_div[l] = DDIV; m_dir[l] = l % 2; m_tick[l] = 0;
                for (int k = 0; k < OPL; k++) m_x[l][k] = XL + k * SP;
            end else begin
                bit wr;
                wr = cfg_we && (int'(cfg_lane) == l);
                if (wr) begin
                    m_div[l] = int'(cfg_div);
                    m_len[l] = (int'(cfg_len) > MLEN) ? MLEN : int'(cfg_len);
                    m_dir[l] = int'(cfg_dir);
                    m_tick[l] = 0;
                end
                if (restart) begin
                    m_tick[l] = 0;
                    for (int k = 0; k < OPL; k++) m_x[l][k] = XL + k * SP;
                end
                if (!wr && !restart && enable) begin
                    m_tick[l]++;
                    if (m_tick[l] == m_div[l] + 2) begin
                        m_tick[l] = 0;
                        m_step[l] = 1'b1;
                        for (int k = 0; k < OPL; k++) begin
                            if (m_dir[l] == 0)
                                m_x[l][k] = (m_x[l][k] >= XR) ? XL - m_len[l] : m_x[l][k] + 1;
                            else
                                m_x[l][k] = (m_x[l][k] <= XL - m_len[l]) ? XR : m_x[l][k] - 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [NL*OPL*X_W-1:0] exp_objx();
        logic [NL*OPL*X_W-1:0] r;
        for (int l = 0; l < NL; l++)
            for (int k = 0; k < OPL; k++)
                r[(l*OPL+k)*X_W +: X_W] = X_W'(m_x[l][k]);
        return r;
    endfunction

    function automatic logic [NL*X_W-1:0] exp_len();
        logic [NL*X_W-1:0] r;
        for (int l = 0; l < NL; l++) r[l*X_W +: X_W] = X_W'(m_len[l]);
        return r;
    endfunction

    function automatic logic [NL-1:0] exp_dir();
        logic [NL-1:0] r;
        for (int l = 0; l < NL; l++) r[l] = m_dir[l][0];
        return r;
    endfunction

    function automatic int dut_x(input int l, input int k);
        return int'(obj_x[(l*OPL+k)*X_W +: X_W]);
    endfunction

    task automatic write_cfg(input int lane, input int div, input int len, input int dir);
        cfg_we = 1'b1; cfg_lane = 3'(lane); cfg_div = CNT_W'(div);
        cfg_len = X_W'(len); cfg_dir = dir[0];
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic step_lane(input int l, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            cycle();
            if (m_step[l]) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; restart = 1'b0; cfg_we = 1'b0;
        cfg_lane = '0; cfg_div = '0; cfg_len = '0; cfg_dir = 1'b0;
        cycle(); cycle();
        reset = 1'b0;
        for (int k = 0; k < OPL; k++) begin
            vectors++;
            if (dut_x(0, k) !== XL + k * SP) begin
                miscompares++;
                $display("FAIL reset_x%0d got %0d want %0d", k, dut_x(0, k), XL + k * SP);
            end
        end
        vectors++;
        if (lane_step !== '0) begin
            miscompares++; $display("FAIL reset_step got %b want 0", lane_step);
        end
        vectors++;
        if (lane_dir !== 6'b101010) begin
            miscompares++; $display("FAIL reset_dir got %b want 101010", lane_dir);
        end
        vectors++;
        if (lane_len !== exp_len()) begin
            miscompares++; $display("FAIL reset_len got %h want %h", lane_len, exp_len());
        end
    endtask

    task automatic test_basic_step();
        enable = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cycle();
            vectors++;
            if (lane_step[0] !== (c % 5 == 0)) begin
                miscompares++;
                $display("FAIL basic_step c=%0d got %b want %b", c, lane_step[0], (c % 5 == 0));
            end
            vectors++;
            if (obj_x !== exp_objx()) begin
                miscompares++; $display("FAIL basic_objx c=%0d got %h want %h", c, obj_x, exp_objx());
            end
        end
        vectors++;
        if (dut_x(0, 0) !== 98) begin
            miscompares++; $display("FAIL basic_x0 got %0d want 98", dut_x(0, 0));
        end
    endtask

    task automatic test_right_wrap();
        bit ok;
        write_cfg(0, 0, 64, 0);
        for (int s = 0; s < 400 && m_x[0][2] != XR; s++) step_lane(0, ok);
        vectors++;
        if (dut_x(0, 2) !== XR) begin
            miscompares++; $display("FAIL rwrap_reach got %0d want %0d", dut_x(0, 2), XR);
        end
        step_lane(0, ok);
        vectors++;
        if (!ok || lane_step[0] !== 1'b1 || dut_x(0, 2) !== 32) begin
            miscompares++;
            $display("FAIL rwrap_wrap got x=%0d step=%b want x=32 step=1", dut_x(0, 2), lane_step[0]);
        end
        step_lane(0, ok);
        vectors++;
        if (dut_x(0, 2) !== 33) begin
            miscompares++; $display("FAIL rwrap_next got %0d want 33", dut_x(0, 2));
        end
    endtask

    task automatic test_left_wrap();
        bit ok;
        write_cfg(1, 0, 64, 1);
        for (int s = 0; s < 1000 && m_x[1][0] != 32; s++) step_lane(1, ok);
        step_lane(1, ok);
        vectors++;
        if (dut_x(1, 0) !== XR) begin
            miscompares++; $display("FAIL lwrap_wrap got %0d want %0d", dut_x(1, 0), XR);
        end
        for (int s = 0; s < 1000 && m_x[1][0] != 100; s++) step_lane(1, ok);
        step_lane(1, ok);
        vectors++;
        if (dut_x(1, 0) !== 99) begin
            miscompares++; $display("FAIL lwrap_dec got %0d want 99", dut_x(1, 0));
        end
    endtask

    task automatic test_cfg_clamp();
        write_cfg(2, 0, 200, 1);
        vectors++;
        if (lane_len[2*X_W +: X_W] !== 10'd96 || lane_dir[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_clamp got len=%0d dir=%b want len=96 dir=1", lane_len[2*X_W +: X_W], lane_dir[2]);
        end
        for (int c = 1; c <= 6; c++) begin
            cycle();
            vectors++;
            if (lane_step[2] !== (c % 2 == 0)) begin
                miscompares++;
                $display("FAIL cfg_div0 c=%0d got %b want %b", c, lane_step[2], (c % 2 == 0));
            end
        end
        write_cfg(7, 9, 10, 0);
        vectors++;
        if (lane_len !== exp_len() || lane_dir !== exp_dir() || lane_len[2*X_W +: X_W] !== 10'd96) begin
            miscompares++;
            $display("FAIL cfg_badlane got len=%h dir=%b want len=%h dir=%b", lane_len, lane_dir, exp_len(), exp_dir());
        end
    endtask

    task automatic test_freeze();
        logic [NL*OPL*X_W-1:0] frozen;
        write_cfg(0, 3, 64, 0);
        cycle(); cycle();
        frozen = exp_objx();
        enable = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            vectors++;
            if (lane_step !== '0 || obj_x !== frozen) begin
                miscompares++;
                $display("FAIL freeze c=%0d got step=%b x=%h want step=0 x=%h", c, lane_step, obj_x, frozen);
            end
        end
        enable = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            cycle();
            vectors++;
            if (lane_step[0] !== (c == 3)) begin
                miscompares++;
                $display("FAIL resume c=%0d got %b want %b", c, lane_step[0], (c == 3));
            end
        end
    endtask

    task automatic test_coincide();
        write_cfg(0, 3, 64, 0);
        cycle(); cycle(); cycle();
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        vectors++;
        if (dut_x(0, 0) !== 96 || dut_x(0, 1) !== 246 || dut_x(0, 2) !== 396 || lane_step !== '0) begin
            miscompares++;
            $display("FAIL restart_tc got x=%0d/%0d/%0d step=%b want 96/246/396 step=0",
                     dut_x(0, 0), dut_x(0, 1), dut_x(0, 2), lane_step);
        end
        vectors++;
        if (lane_len[0 +: X_W] !== 10'd64 || lane_len !== exp_len()) begin
            miscompares++; $display("FAIL restart_cfg got %h want %h", lane_len, exp_len());
        end
        cycle();
        vectors++;
        if (lane_step[0] !== 1'b0) begin
            miscompares++; $display("FAIL restart_cancel got %b want 0", lane_step[0]);
        end
        write_cfg(0, 3, 64, 0);
        cycle(); cycle(); cycle();
        write_cfg(0, 3, 64, 0);
        for (int c = 1; c <= 5; c++) begin
            cycle();
            vectors++;
            if (lane_step[0] !== (c == 5)) begin
                miscompares++;
                $display("FAIL write_tc c=%0d got %b want %b", c, lane_step[0], (c == 5));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            reset    = ($urandom_range(0, 399) == 0);
            enable   = ($urandom_range(0, 4) != 0);
            restart  = ($urandom_range(0, 49) == 0);
            cfg_we   = ($urandom_range(0, 9) == 0);
            cfg_lane = 3'($urandom_range(0, 7));
            cfg_div  = CNT_W'($urandom_range(0, 6));
            cfg_len  = X_W'($urandom_range(0, 150));
            cfg_dir  = 1'($urandom_range(0, 1));
            cycle();
            vectors++;
            if (obj_x !== exp_objx() || lane_step !== m_step ||
                lane_len !== exp_len() || lane_dir !== exp_dir()) begin
                miscompares++;
                $display("FAIL random c=%0d got x=%h st=%b len=%h dir=%b want x=%h st=%b len=%h dir=%b",
                         c, obj_x, lane_step, lane_len, lane_dir, exp_objx(), m_step, exp_len(), exp_dir());
            end
        end
        reset = 1'b0; restart = 1'b0; cfg_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_step();
        test_right_wrap();
        test_left_wrap();
        test_cfg_clamp();
        test_freeze();
        test_coincide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
